// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles the I-side request port, the D-side request port and the single
//   memory port of mem_port_arbiter.
//   slave  : arbiter view (requests and memory response in; acks, read data,
//            memory command and owner_d out)
//   master : environment view (caches plus backing store), the mirror image
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // I-side (instruction-cache refill, read only)
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;
    logic              i_err;

    // D-side (data-cache load miss / store write-through)
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    // Backing-store port
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic              owner_d;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
               mem_req, mem_we, mem_addr, mem_wdata, owner_d
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
               mem_req, mem_we, mem_addr, mem_wdata, owner_d
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port memory between I-cache refills and D-cache
//   loads/stores. One transaction at a time, round-robin on simultaneous
//   requests, and a watchdog that aborts a memory access that never acks.
//
//   clock : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : mem_port_arbiter_if.slave (request ports, acks, memory port)
//
//   Flow: IDLE -> GRANT_I | GRANT_D -> RESP -> IDLE. Every output is a
//   register; x_ack is high for the single RESP cycle.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64,
    parameter bit D_FIRST = 1'b1
) (
    input logic                 clock,
    input logic                 reset,
    mem_port_arbiter_if.slave   bus
);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RESP} state_t;

    state_t            state, state_nx;
    logic              rr_d, rr_d_nx;        // 1: D-side wins the next tie
    logic [WD_W-1:0]   wd, wd_nx;            // GRANT cycles elapsed

    logic              i_ack_r, i_ack_nx;
    logic              i_err_r, i_err_nx;
    logic [DATA_W-1:0] i_rdata_r, i_rdata_nx;
    logic              d_ack_r, d_ack_nx;
    logic              d_err_r, d_err_nx;
    logic [DATA_W-1:0] d_rdata_r, d_rdata_nx;
    logic              mem_req_r, mem_req_nx;
    logic              mem_we_r, mem_we_nx;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_nx;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_nx;
    logic              owner_d_r, owner_d_nx;

    logic              grant_d;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_data;

    // D wins when it is the only requester, or on a tie when the pointer names it.
    assign grant_d  = bus.d_req && (!bus.i_req || rr_d);

    // Leaving GRANT without mem_ack can only mean the watchdog fired.
    assign rsp_err  = !bus.mem_ack;
    assign rsp_data = (bus.mem_ack && !mem_we_r) ? bus.mem_rdata : '0;

    // NOTE: every signal gets its default before the case so that no path
    // leaves it unassigned; otherwise a latch is inferred.
    always_comb begin
        state_nx     = state;
        rr_d_nx      = rr_d;
        wd_nx        = wd;
        i_ack_nx     = 1'b0;
        i_err_nx     = 1'b0;
        i_rdata_nx   = '0;
        d_ack_nx     = 1'b0;
        d_err_nx     = 1'b0;
        d_rdata_nx   = '0;
        mem_req_nx   = mem_req_r;
        mem_we_nx    = mem_we_r;
        mem_addr_nx  = mem_addr_r;
        mem_wdata_nx = mem_wdata_r;
        owner_d_nx   = owner_d_r;

        unique case (state)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    state_nx     = grant_d ? GRANT_D : GRANT_I;
                    rr_d_nx      = !grant_d;
                    wd_nx        = '0;
                    // Memory command is loaded now so mem_req is up in the
                    // first GRANT cycle.
                    mem_req_nx   = 1'b1;
                    mem_we_nx    = grant_d && bus.d_we;
                    mem_addr_nx  = (grant_d ? bus.d_addr : bus.i_addr) & ALIGN_MASK;
                    mem_wdata_nx = grant_d ? bus.d_wdata : '0;
                    owner_d_nx   = grant_d;
                end
            end

            GRANT_I, GRANT_D: begin
                wd_nx = wd + WD_W'(1);
                if (bus.mem_ack || wd == WD_W'(TIMEOUT - 1)) begin
                    state_nx   = RESP;
                    mem_req_nx = 1'b0;
                    if (state == GRANT_D) begin
                        d_ack_nx   = 1'b1;
                        d_err_nx   = rsp_err;
                        d_rdata_nx = rsp_data;
                    end else begin
                        i_ack_nx   = 1'b1;
                        i_err_nx   = rsp_err;
                        i_rdata_nx = rsp_data;
                    end
                end
            end

            RESP: begin
                // Requests are deliberately not sampled here: the requester
                // drops req on the edge where it sees ack.
                state_nx   = IDLE;
                owner_d_nx = 1'b0;
            end

            default: state_nx = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rr_d        <= D_FIRST;
            wd          <= '0;
            i_ack_r     <= 1'b0;
            i_err_r     <= 1'b0;
            i_rdata_r   <= '0;
            d_ack_r     <= 1'b0;
            d_err_r     <= 1'b0;
            d_rdata_r   <= '0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            owner_d_r   <= 1'b0;
        end else begin
            state       <= state_nx;
            rr_d        <= rr_d_nx;
            wd          <= wd_nx;
            i_ack_r     <= i_ack_nx;
            i_err_r     <= i_err_nx;
            i_rdata_r   <= i_rdata_nx;
            d_ack_r     <= d_ack_nx;
            d_err_r     <= d_err_nx;
            d_rdata_r   <= d_rdata_nx;
            mem_req_r   <= mem_req_nx;
            mem_we_r    <= mem_we_nx;
            mem_addr_r  <= mem_addr_nx;
            mem_wdata_r <= mem_wdata_nx;
            owner_d_r   <= owner_d_nx;
        end
    end

    assign bus.i_ack     = i_ack_r;
    assign bus.i_err     = i_err_r;
    assign bus.i_rdata   = i_rdata_r;
    assign bus.d_ack     = d_ack_r;
    assign bus.d_err     = d_err_r;
    assign bus.d_rdata   = d_rdata_r;
    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.owner_d   = owner_d_r;

endmodule
